bus_mem_responder: RTL and testbench

Memory-side responder for the cached-fetch bus protocol: accepts line-fill read requests from the instruction-cache initiator and returns each line as a burst of 64-bit beats tagged with the request tag. It sits between the bus and a synchronous-read backing memory and buffers up to FIFO_DEPTH outstanding requests. Read-only: every accepted request is treated as a line read.

---
 rtl/bus_mem_responder_if.sv | 28 ++
 rtl/bus_mem_responder.sv | 140 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// Bus and backing-memory signal bundle for bus_mem_responder.
// slave = responder side; master = initiator plus backing memory.
interface bus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      mem_rd;
  logic [63:0]               mem_addr;
  logic [63:0]               mem_rdata;

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack, mem_rdata,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag, mem_rd, mem_addr
  );

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack, mem_rdata,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, mem_rd, mem_addr
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Line-fill responder: queues read requests, returns each line as BURST_LEN tagged beats (BUS_CRITICAL_WORD_FIRST_EN: wrap from requested word).
// Latency: first beat 3 cycles after ack, 3 cycles/beat; backpressure: reqack withheld at FIFO_DEPTH outstanding, beat held until respack.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_LEN      = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                clk,
  input logic                reset,
  bus_mem_responder_if.slave bus
);
  localparam int OFS_W = $clog2(BURST_LEN * 8);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0] LINE_MASK = ~((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND} state_e;

  state_e                    state_q;
  logic [BUS_DATA_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [BUS_TAG_WIDTH-1:0]  fifo_tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [OCC_W:0]            outstanding;
  logic                      push, pop, reqack_q;

  logic [CNT_W-1:0]          cnt_q, word_idx, next_idx, first_idx;
  logic [63:0]               base_q, head_base, mem_addr_q;
  logic [BUS_DATA_WIDTH-1:0] head_addr, resp_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic                      respcyc_q, mem_rd_q;

  // The request being served still holds a slot, so the cap covers queued plus in-flight.
  always_comb begin
    outstanding = {1'b0, occ_q} + (OCC_W + 1)'(state_q != S_IDLE);
    push        = bus.bus_reqcyc && !reqack_q && (outstanding < (OCC_W + 1)'(FIFO_DEPTH));
    pop         = (state_q == S_IDLE) && (occ_q != '0);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.bus_req;
      fifo_tag_q[wr_ptr_q]  <= bus.bus_reqtag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      reqack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      reqack_q <= push;
    end
  end

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_base = 64'(head_addr) & LINE_MASK;

`ifdef BUS_CRITICAL_WORD_FIRST_EN
  logic [CNT_W-1:0] start_q;
  assign first_idx = head_addr[OFS_W-1:3];
  assign word_idx  = start_q + cnt_q;
`else
  assign first_idx = '0;
  assign word_idx  = cnt_q;
`endif
  assign next_idx = word_idx + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      tag_q      <= '0;
      resp_q     <= '0;
      respcyc_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef BUS_CRITICAL_WORD_FIRST_EN
      start_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            base_q     <= head_base;
            tag_q      <= fifo_tag_q[rd_ptr_q];
            cnt_q      <= '0;
`ifdef BUS_CRITICAL_WORD_FIRST_EN
            start_q    <= first_idx;
`endif
            mem_rd_q   <= 1'b1;
            mem_addr_q <= head_base | 64'({first_idx, 3'b000});
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          resp_q    <= BUS_DATA_WIDTH'(bus.mem_rdata);
          respcyc_q <= 1'b1;
          state_q   <= S_SEND;
        end
        S_SEND: begin
          if (bus.bus_respack) begin
            respcyc_q <= 1'b0;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q      <= cnt_q + CNT_W'(1);
              mem_rd_q   <= 1'b1;
              mem_addr_q <= base_q | 64'({next_idx, 3'b000});
              state_q    <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_reqack  = reqack_q;
  assign bus.bus_respcyc = respcyc_q;
  assign bus.bus_resp    = resp_q;
  assign bus.bus_resptag = tag_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder; plays the initiator and a synchronous-read backing memory.
module tb_bus_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          rd_cnt = 0;
  logic [63:0] last_rd_addr = '0;
  int          last_ack_cyc = 0;
  int          first_vld_cyc = 0;

  bus_mem_responder_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bif ();

  bus_mem_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BURST_LEN(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_F00D, a[31:0]};
  endfunction

  // Backing memory: data for the address strobed at one edge is presented from that edge on.
  always @(posedge clk) begin
    if (bif.mem_rd === 1'b1) begin
      bif.mem_rdata <= mem_word(bif.mem_addr);
      rd_cnt        <= rd_cnt + 1;
      last_rd_addr  <= bif.mem_addr;
    end
  end

  task automatic issue_req(input logic [63:0] addr, input logic [12:0] tag, output int ack_at);
    int t;
    t = 0;
    ack_at = -1;
    bif.bus_reqcyc = 1'b1;
    bif.bus_req    = addr;
    bif.bus_reqtag = tag;
    while (t < 100) begin
      @(posedge clk); #1;
      t++;
      if (bif.bus_reqack === 1'b1) begin
        ack_at = cyc;
        break;
      end
    end
    bif.bus_reqcyc = 1'b0;
    checks++;
    if (ack_at < 0) $display("FAIL req_ack addr=%h: no reqack within %0d cycles, required one", addr, t);
    else passes++;
  endtask

  task automatic consume_burst(input logic [63:0] addrs [8], input logic [12:0] tag,
                               input int n_beats, input int stall_beat, input bit check_gap);
    int t;
    int rd_snap;
    for (int b = 0; b < n_beats; b++) begin
      t = 0;
      while (bif.bus_respcyc !== 1'b1 && t < 60) begin
        @(posedge clk); #1;
        t++;
      end
      checks++;
      if (bif.bus_respcyc !== 1'b1) begin
        $display("FAIL beat_valid tag=%h beat=%0d: respcyc=%b after %0d cycles, required 1", tag, b, bif.bus_respcyc, t);
        return;
      end
      passes++;
      if (b == 0) first_vld_cyc = cyc;
      else if (check_gap) begin
        checks++;
        if (cyc !== last_ack_cyc + 2)
          $display("FAIL beat_gap beat=%0d: valid at cycle %0d, required %0d", b, cyc, last_ack_cyc + 2);
        else passes++;
      end
      checks++;
      if (last_rd_addr !== addrs[b])
        $display("FAIL mem_addr beat=%0d: got %h, required %h", b, last_rd_addr, addrs[b]);
      else passes++;
      checks++;
      if (bif.bus_resp !== mem_word(addrs[b]))
        $display("FAIL beat_data beat=%0d: got %h, required %h", b, bif.bus_resp, mem_word(addrs[b]));
      else passes++;
      checks++;
      if (bif.bus_resptag !== tag)
        $display("FAIL beat_tag beat=%0d: got %h, required %h", b, bif.bus_resptag, tag);
      else passes++;
      if (b == stall_beat) begin
        rd_snap = rd_cnt;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          checks++;
          if (bif.bus_respcyc !== 1'b1 || bif.bus_resp !== mem_word(addrs[b]) ||
              bif.bus_resptag !== tag || rd_cnt !== rd_snap)
            $display("FAIL stall_hold cycle=%0d: vld=%b data=%h tag=%h reads=%0d, required 1/%h/%h/%0d",
                     s, bif.bus_respcyc, bif.bus_resp, bif.bus_resptag, rd_cnt,
                     mem_word(addrs[b]), tag, rd_snap);
          else passes++;
        end
      end
      bif.bus_respack = 1'b1;
      @(posedge clk); #1;
      bif.bus_respack = 1'b0;
      last_ack_cyc = cyc;
      if (check_gap) begin
        checks++;
        if (bif.bus_respcyc !== 1'b0)
          $display("FAIL vld_drop beat=%0d: respcyc=%b after ack, required 0", b, bif.bus_respcyc);
        else passes++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.bus_reqack !== 1'b0) $display("FAIL rst_reqack: got %b, required 0", bif.bus_reqack); else passes++;
    checks++; if (bif.bus_respcyc !== 1'b0) $display("FAIL rst_respcyc: got %b, required 0", bif.bus_respcyc); else passes++;
    checks++; if (bif.bus_resp !== 64'h0) $display("FAIL rst_resp: got %h, required 0", bif.bus_resp); else passes++;
    checks++; if (bif.bus_resptag !== 13'h0) $display("FAIL rst_resptag: got %h, required 0", bif.bus_resptag); else passes++;
    checks++; if (bif.mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b, required 0", bif.mem_rd); else passes++;
    checks++; if (bif.mem_addr !== 64'h0) $display("FAIL rst_mem_addr: got %h, required 0", bif.mem_addr); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [63:0] a [8];
    int n;
    for (int i = 0; i < 8; i++) a[i] = 64'h1000 + 64'(i * 8);
    issue_req(64'h1000, 13'h5, n);
    @(posedge clk); #1;
    checks++; if (bif.bus_reqack !== 1'b0) $display("FAIL ack_pulse: reqack=%b one cycle after ack, required 0", bif.bus_reqack); else passes++;
    checks++;
    if (bif.mem_rd !== 1'b1 || bif.mem_addr !== 64'h1000)
      $display("FAIL first_fetch: mem_rd=%b mem_addr=%h, required 1/0000000000001000", bif.mem_rd, bif.mem_addr);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (bif.mem_rd !== 1'b0 || bif.bus_respcyc !== 1'b0)
      $display("FAIL load_cycle: mem_rd=%b respcyc=%b, required 0/0", bif.mem_rd, bif.bus_respcyc);
    else passes++;
    consume_burst(a, 13'h5, 8, -1, 1'b1);
    checks++;
    if (first_vld_cyc !== n + 3) $display("FAIL first_latency: valid at %0d, required %0d", first_vld_cyc, n + 3);
    else passes++;
  endtask

  task automatic test_critical_word;
    logic [63:0] a [8];
    int n;
`ifdef BUS_CRITICAL_WORD_FIRST_EN
    a = '{64'h1018, 64'h1020, 64'h1028, 64'h1030, 64'h1038, 64'h1000, 64'h1008, 64'h1010};
`else
    a = '{64'h1000, 64'h1008, 64'h1010, 64'h1018, 64'h1020, 64'h1028, 64'h1030, 64'h1038};
`endif
    issue_req(64'h1018, 13'h0A, n);
    consume_burst(a, 13'h0A, 8, -1, 1'b0);
  endtask

  task automatic test_stall;
    logic [63:0] a [8];
    int n;
    for (int i = 0; i < 8; i++) a[i] = 64'h2040 + 64'(i * 8);
    issue_req(64'h2040, 13'h77, n);
    consume_burst(a, 13'h77, 8, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [63:0] addrs [5];
    logic [12:0] tags [5];
    int n, b1_end, b2_start, ack5, t5;
    bit hold;
    addrs = '{64'h3000, 64'h3040, 64'h3080, 64'h30C0, 64'h3100};
    tags  = '{13'h101, 13'h202, 13'h303, 13'h404, 13'h1ABC};
    b1_end = 0;
    b2_start = 0;
    ack5 = -1;
    for (int i = 0; i < 4; i++) issue_req(addrs[i], tags[i], n);
    bif.bus_reqcyc = 1'b1;
    bif.bus_req    = addrs[4];
    bif.bus_reqtag = tags[4];
    hold = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bif.bus_reqack !== 1'b0) hold = 1'b0;
    end
    checks++; if (!hold) $display("FAIL fifth_stall: reqack=1 with four outstanding, required 0"); else passes++;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic [63:0] a [8];
          for (int k = 0; k < 8; k++) a[k] = addrs[i] + 64'(k * 8);
          consume_burst(a, tags[i], 8, -1, 1'b0);
          if (i == 0) b1_end = last_ack_cyc;
          if (i == 1) b2_start = first_vld_cyc;
        end
      end
      begin
        t5 = 0;
        while (t5 < 400) begin
          @(posedge clk); #1;
          t5++;
          if (bif.bus_reqack === 1'b1) begin
            ack5 = cyc;
            break;
          end
        end
        bif.bus_reqcyc = 1'b0;
      end
    join
    checks++;
    if (ack5 !== b1_end + 1) $display("FAIL fifth_ack: acked at %0d, required %0d", ack5, b1_end + 1);
    else passes++;
    checks++;
    if (b2_start !== b1_end + 3) $display("FAIL idle_turnaround: burst 2 valid at %0d, required %0d", b2_start, b1_end + 3);
    else passes++;
  endtask

  task automatic test_reset_mid_burst;
    logic [63:0] a [8];
    int n, t, rd_snap;
    bit quiet;
    for (int i = 0; i < 8; i++) a[i] = 64'h4000 + 64'(i * 8);
    issue_req(64'h4000, 13'h111, n);
    issue_req(64'h4040, 13'h222, n);
    issue_req(64'h4080, 13'h333, n);
    consume_burst(a, 13'h111, 3, -1, 1'b0);
    t = 0;
    while (bif.bus_respcyc !== 1'b1 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    checks++; if (bif.bus_respcyc !== 1'b1) $display("FAIL beat4_valid: respcyc=%b, required 1", bif.bus_respcyc); else passes++;
    rd_snap = rd_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bif.bus_respcyc !== 1'b0) $display("FAIL mid_rst_respcyc: got %b, required 0", bif.bus_respcyc); else passes++;
    checks++; if (bif.bus_resp !== 64'h0) $display("FAIL mid_rst_resp: got %h, required 0", bif.bus_resp); else passes++;
    checks++; if (bif.bus_resptag !== 13'h0) $display("FAIL mid_rst_resptag: got %h, required 0", bif.bus_resptag); else passes++;
    quiet = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (bif.bus_respcyc !== 1'b0 || bif.bus_reqack !== 1'b0 || bif.mem_rd !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || rd_cnt !== rd_snap)
      $display("FAIL post_rst_quiet: activity=%b reads=%0d, required 0/%0d", !quiet, rd_cnt, rd_snap);
    else passes++;
    for (int i = 0; i < 8; i++) a[i] = 64'h5000 + 64'(i * 8);
    issue_req(64'h5000, 13'h1FFF, n);
    consume_burst(a, 13'h1FFF, 8, -1, 1'b1);
    checks++;
    if (first_vld_cyc !== n + 3) $display("FAIL post_rst_latency: valid at %0d, required %0d", first_vld_cyc, n + 3);
    else passes++;
  endtask

  initial begin
    reset           = 1'b1;
    bif.bus_reqcyc  = 1'b0;
    bif.bus_req     = '0;
    bif.bus_reqtag  = '0;
    bif.bus_respack = 1'b0;
    test_reset();
    test_basic();
    test_critical_word();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
